// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
// Purpose : Encodings shared between the control unit and the branch unit.
//           The control unit produces the branch code and the conditional
//           kind; the branch unit consumes them. Keeping both here means the
//           two blocks cannot drift apart.
// Contents: branch_e    - 3-bit branch code
//           cond_e      - 2-bit conditional kind used with BR_COND
//           bu_state_e  - branch unit sequencing states
//           PC_STEP     - size of one instruction in bytes
//           rel_target  - pc + 4 + (sign-extended word offset << 2)
// ---------------------------------------------------------------------------
package risc_pkg;

  // Branch codes. 000 and 111 both mean "no branch"; 111 gets its own
  // name so that a decoder can still be exhaustive.
  typedef enum logic [2:0] {
    BR_NONE     = 3'b000,
    BR_REG      = 3'b001,
    BR_COND     = 3'b010,
    BR_B        = 3'b011,
    BR_BL       = 3'b100,
    BR_BCY      = 3'b101,
    BR_BNCY     = 3'b110,
    BR_NONE_ALT = 3'b111
  } branch_e;

  // Conditional kinds, selected by cond_sel when the branch code is BR_COND.
  typedef enum logic [1:0] {
    COND_BLTZ  = 2'b00,
    COND_BZ    = 2'b01,
    COND_BNZ   = 2'b10,
    COND_NEVER = 2'b11
  } cond_e;

  // RUN accepts instructions. FLUSH covers the single cycle that squashes the
  // wrong-path instruction sitting in decode after a taken branch.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bu_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // The offset counts words, so it is shifted left by two and sign-extended
  // to 32 bits. The addition wraps naturally at 2^32.
  function automatic logic [31:0] rel_target(input logic [31:0] pc,
                                             input logic [25:0] imm);
    logic [31:0] offset;
    offset = {{4{imm[25]}}, imm, 2'b00};
    return pc + PC_STEP + offset;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Purpose : Purely combinational decision: would this branch be taken?
//           It does not know whether the instruction is actually accepted;
//           the caller qualifies o_take with its own accept condition.
// Ports   : i_branch   [2:0]  branch code (risc_pkg::branch_e)
//           i_cond_sel [1:0]  conditional kind (risc_pkg::cond_e)
//           i_rs_value [31:0] register operand tested by the conditionals
//           i_carry_q         registered ALU carry flag
//           o_take            1 when the branch condition holds
// ---------------------------------------------------------------------------
module branch_cond
  import risc_pkg::*;
(
  input  logic [2:0]  i_branch,
  input  logic [1:0]  i_cond_sel,
  input  logic [31:0] i_rs_value,
  input  logic        i_carry_q,
  output logic        o_take
);

  branch_e w_branch;
  cond_e   w_cond;

  // Both enums cover every bit pattern of their width, so the casts are
  // always to a named value.
  assign w_branch = branch_e'(i_branch);
  assign w_cond   = cond_e'(i_cond_sel);

  // Unconditional kinds always take. COND_NEVER and the two "none" codes
  // fall through to the not-taken default.
  always_comb begin
    o_take = 1'b0;
    case (w_branch)
      BR_REG, BR_B, BR_BL: o_take = 1'b1;
      BR_COND: begin
        case (w_cond)
          COND_BLTZ: o_take = i_rs_value[31];
          COND_BZ:   o_take = (i_rs_value == 32'd0);
          COND_BNZ:  o_take = (i_rs_value != 32'd0);
          default:   o_take = 1'b0;
        endcase
      end
      BR_BCY:  o_take = i_carry_q;
      BR_BNCY: o_take = ~i_carry_q;
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
// Purpose : Owns the program counter. Sequential instructions advance it by
//           four; taken branches redirect it and then spend one FLUSH cycle
//           squashing the wrong-path instruction in decode. Also keeps the
//           ALU carry flag used by bcy/bncy and produces the bl link write.
// Params  : RESET_PC           PC value loaded by reset
// Ports   : clk                rising-edge clock
//           rst_n              asynchronous active-low reset
//           i_instr_valid      decoded instruction present this cycle
//           i_stall            freezes every piece of state while high
//           i_branch    [2:0]  branch code
//           i_cond_sel  [1:0]  conditional kind
//           i_rs_value  [31:0] test operand, or target for br
//           i_imm       [25:0] signed word offset for relative branches
//           i_flag_we          carry update strobe
//           i_carry_in         ALU carry-out
//           o_pc        [31:0] current PC
//           o_taken            high for one cycle after an accepted taken branch
//           o_flush            squash the instruction currently in decode
//           o_link_we          one-cycle link register write strobe
//           o_link_data [31:0] return address captured from the last bl
// ---------------------------------------------------------------------------
module branch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  input  logic        i_stall,
  input  logic [2:0]  i_branch,
  input  logic [1:0]  i_cond_sel,
  input  logic [31:0] i_rs_value,
  input  logic [25:0] i_imm,
  input  logic        i_flag_we,
  input  logic        i_carry_in,
  output logic [31:0] o_pc,
  output logic        o_taken,
  output logic        o_flush,
  output logic        o_link_we,
  output logic [31:0] o_link_data
);

  bu_state_e   r_state;
  bu_state_e   w_state_next;
  logic [31:0] r_pc;
  logic        r_carry_q;
  logic        r_taken;
  logic        r_link_we;
  logic [31:0] r_link_data;

  logic        w_accept;
  logic        w_cond_take;
  logic        w_take;
  logic        w_is_bl;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  // Instructions arriving during FLUSH are on the wrong path, so they are
  // never accepted, whatever i_instr_valid says.
  assign w_accept   = i_instr_valid && !i_stall && (r_state == ST_RUN);
  assign w_take     = w_accept && w_cond_take;
  assign w_is_bl    = (branch_e'(i_branch) == BR_BL);
  assign w_pc_plus4 = r_pc + PC_STEP;
  assign w_target   = (branch_e'(i_branch) == BR_REG) ? i_rs_value
                                                      : rel_target(r_pc, i_imm);

  // The carry passed in is the registered one, so a flag write in the same
  // cycle as bcy/bncy only affects the following instruction.
  branch_cond u_branch_cond (
    .i_branch   (i_branch),
    .i_cond_sel (i_cond_sel),
    .i_rs_value (i_rs_value),
    .i_carry_q  (r_carry_q),
    .o_take     (w_cond_take)
  );

  // FLUSH lasts exactly one unstalled cycle; the stall gate lives in the
  // state register so a stalled FLUSH simply persists.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_take) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (!i_stall) begin
      r_state <= w_state_next;
    end
  end

  // PC only moves on an accepted instruction; the FLUSH cycle and stalls
  // leave it where the branch put it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_accept) begin
      r_pc <= w_take ? w_target : w_pc_plus4;
    end
  end

  // Carry tracks the ALU regardless of FSM state, but not while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_q <= 1'b0;
    end else if (i_flag_we && !i_stall) begin
      r_carry_q <= i_carry_in;
    end
  end

  // Single-cycle status strobes: each unstalled cycle reloads them, so they
  // drop on their own unless another qualifying accept follows. Link data is
  // kept until the next bl so the write port sees a stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken     <= 1'b0;
      r_link_we   <= 1'b0;
      r_link_data <= 32'd0;
    end else if (!i_stall) begin
      r_taken   <= w_take;
      r_link_we <= w_accept && w_is_bl;
      if (w_accept && w_is_bl) begin
        r_link_data <= w_pc_plus4;
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_taken     = r_taken;
  assign o_flush     = (r_state == ST_FLUSH);
  assign o_link_we   = r_link_we;
  assign o_link_data = r_link_data;

endmodule

// File: tb/tb_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_unit
// Purpose : Self-checking bench for branch_unit. A behavioural model tracks
//           the architectural state (PC, carry, pending flush, strobes) and is
//           stepped once per clock; a directed table and a few hand-written
//           sequences add explicit expected values for the corner cases.
// ---------------------------------------------------------------------------
module tb_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        instrValid;
  logic        stall;
  logic [2:0]  branch;
  logic [1:0]  condSel;
  logic [31:0] rsValue;
  logic [25:0] imm;
  logic        flagWe;
  logic        carryIn;
  logic [31:0] pc;
  logic        taken;
  logic        flush;
  logic        linkWe;
  logic [31:0] linkData;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [31:0] mPc;
  logic        mCarry;
  logic        mFlush;
  logic        mTaken;
  logic        mLinkWe;
  logic [31:0] mLinkData;

  typedef struct {
    logic        valid;
    logic [2:0]  br;
    logic [1:0]  cs;
    logic [31:0] rs;
    logic [25:0] im;
    logic        fwe;
    logic        cin;
    logic [31:0] ePc;
    logic        eTaken;
    logic        eFlush;
    logic        eLinkWe;
    logic [31:0] eLinkData;
  } vec_t;

  vec_t tbl [19];

  branch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_instr_valid (instrValid),
    .i_stall       (stall),
    .i_branch      (branch),
    .i_cond_sel    (condSel),
    .i_rs_value    (rsValue),
    .i_imm         (imm),
    .i_flag_we     (flagWe),
    .i_carry_in    (carryIn),
    .o_pc          (pc),
    .o_taken       (taken),
    .o_flush       (flush),
    .o_link_we     (linkWe),
    .o_link_data   (linkData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [2:0] b, logic [1:0] c,
                              logic [31:0] r, logic [25:0] i, logic fw,
                              logic ci, logic [31:0] p, logic t, logic f,
                              logic lw, logic [31:0] ld);
    vec_t x;
    x.valid = v; x.br = b; x.cs = c; x.rs = r; x.im = i; x.fwe = fw;
    x.cin = ci; x.ePc = p; x.eTaken = t; x.eFlush = f; x.eLinkWe = lw;
    x.eLinkData = ld;
    return x;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual,
                             logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Branch decision straight from the rule list.
  function automatic logic modelTake(logic [2:0] b, logic [1:0] c,
                                     logic [31:0] r, logic cy);
    if (b == 3'd1 || b == 3'd3 || b == 3'd4) return 1'b1;
    if (b == 3'd2) begin
      if (c == 2'd0) return r[31];
      if (c == 2'd1) return r == 0;
      if (c == 2'd2) return r != 0;
      return 1'b0;
    end
    if (b == 3'd5) return cy;
    if (b == 3'd6) return !cy;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mPc = RST_PC; mCarry = 0; mFlush = 0; mTaken = 0; mLinkWe = 0;
    mLinkData = 0;
  endtask

  task automatic compareModel(string tag);
    checkOutput({tag, ".pc"},       pc,               mPc);
    checkOutput({tag, ".taken"},    {31'd0, taken},   {31'd0, mTaken});
    checkOutput({tag, ".flush"},    {31'd0, flush},   {31'd0, mFlush});
    checkOutput({tag, ".linkWe"},   {31'd0, linkWe},  {31'd0, mLinkWe});
    checkOutput({tag, ".linkData"}, linkData,         mLinkData);
  endtask

  // Drives one cycle of inputs, advances the model by the same cycle,
  // and compares all outputs just after the clock edge.
  task automatic applyStimulus(string tag, logic v, logic s, logic [2:0] b,
                               logic [1:0] c, logic [31:0] r, logic [25:0] i,
                               logic fw, logic ci);
    logic        acc, tk;
    logic [31:0] nextPc;
    instrValid = v; stall = s; branch = b; condSel = c; rsValue = r;
    imm = i; flagWe = fw; carryIn = ci;
    nextPc = mPc;
    if (!s) begin
      acc = v && !mFlush;
      tk  = acc && modelTake(b, c, r, mCarry);
      if (acc) begin
        if (!tk)          nextPc = mPc + 4;
        else if (b == 3'd1) nextPc = r;
        else nextPc = mPc + 4 + ({{6{i[25]}}, i} * 4);
      end
      mLinkWe = acc && (b == 3'd4);
      if (mLinkWe) mLinkData = mPc + 4;
      mFlush = mFlush ? 1'b0 : tk;
      mTaken = tk;
      if (fw) mCarry = ci;
    end
    @(posedge clk);
    #1;
    mPc = nextPc;
    compareModel(tag);
  endtask

  initial begin
    rst_n = 1'b0; instrValid = 0; stall = 0; branch = 0; condSel = 0;
    rsValue = 0; imm = 0; flagWe = 0; carryIn = 0;
    modelReset();

    // Reset values
    #3;
    checkOutput("rst.pc",       pc,                RST_PC);
    checkOutput("rst.taken",    {31'd0, taken},    32'd0);
    checkOutput("rst.flush",    {31'd0, flush},    32'd0);
    checkOutput("rst.linkWe",   {31'd0, linkWe},   32'd0);
    checkOutput("rst.linkData", linkData,          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three sequential accepts from RESET_PC
    for (int k = 1; k <= 3; k++) begin
      applyStimulus("seq", 1, 0, 3'd0, 2'd0, 32'd0, 26'd0, 0, 0);
      checkOutput("seq.pcStep", pc, 32'(4 * k));
      checkOutput("seq.noTaken", {31'd0, taken}, 32'd0);
    end

    // Directed table (starts at pc=0xC)
    tbl[0]  = mk(1,3'd1,2'd0,32'h100,26'd0,0,0,            32'h100,1,1,0,32'h0);
    tbl[1]  = mk(1,3'd0,2'd0,32'h0,26'd0,0,0,              32'h100,0,0,0,32'h0);
    tbl[2]  = mk(1,3'd2,2'd1,32'h0,26'h3FFFFFE,0,0,        32'h0FC,1,1,0,32'h0);
    tbl[3]  = mk(1,3'd0,2'd0,32'h0,26'd0,0,0,              32'h0FC,0,0,0,32'h0);
    tbl[4]  = mk(1,3'd1,2'd0,32'h40,26'd0,0,0,             32'h040,1,1,0,32'h0);
    tbl[5]  = mk(0,3'd0,2'd0,32'h0,26'd0,0,0,              32'h040,0,0,0,32'h0);
    tbl[6]  = mk(1,3'd4,2'd0,32'h0,26'd3,0,0,              32'h050,1,1,1,32'h44);
    tbl[7]  = mk(0,3'd0,2'd0,32'h0,26'd0,0,0,              32'h050,0,0,0,32'h44);
    tbl[8]  = mk(1,3'd5,2'd0,32'h0,26'd5,1,1,              32'h054,0,0,0,32'h44);
    tbl[9]  = mk(1,3'd5,2'd0,32'h0,26'd5,0,0,              32'h06C,1,1,0,32'h44);
    tbl[10] = mk(0,3'd0,2'd0,32'h0,26'd0,1,0,              32'h06C,0,0,0,32'h44);
    tbl[11] = mk(1,3'd6,2'd0,32'h0,26'd0,0,0,              32'h070,1,1,0,32'h44);
    tbl[12] = mk(0,3'd0,2'd0,32'h0,26'd0,0,0,              32'h070,0,0,0,32'h44);
    tbl[13] = mk(1,3'd2,2'd3,32'h0,26'd7,0,0,              32'h074,0,0,0,32'h44);
    tbl[14] = mk(1,3'd7,2'd0,32'h0,26'd7,0,0,              32'h078,0,0,0,32'h44);
    tbl[15] = mk(1,3'd2,2'd0,32'h8000_0000,26'h3FFFFFF,0,0,32'h078,1,1,0,32'h44);
    tbl[16] = mk(0,3'd0,2'd0,32'h0,26'd0,0,0,              32'h078,0,0,0,32'h44);
    tbl[17] = mk(1,3'd2,2'd2,32'h0,26'd4,0,0,              32'h07C,0,0,0,32'h44);
    tbl[18] = mk(1,3'd2,2'd0,32'h1,26'd4,0,0,              32'h080,0,0,0,32'h44);
    for (int n = 0; n < 19; n++) begin
      applyStimulus("tblModel", tbl[n].valid, 0, tbl[n].br, tbl[n].cs,
                    tbl[n].rs, tbl[n].im, tbl[n].fwe, tbl[n].cin);
      checkOutput($sformatf("tbl%0d.pc", n), pc, tbl[n].ePc);
      checkOutput($sformatf("tbl%0d.taken", n), {31'd0, taken},
                  {31'd0, tbl[n].eTaken});
      checkOutput($sformatf("tbl%0d.flush", n), {31'd0, flush},
                  {31'd0, tbl[n].eFlush});
      checkOutput($sformatf("tbl%0d.linkWe", n), {31'd0, linkWe},
                  {31'd0, tbl[n].eLinkWe});
      checkOutput($sformatf("tbl%0d.linkData", n), linkData, tbl[n].eLinkData);
    end

    // Stall held during FLUSH
    applyStimulus("stallEnter", 1, 0, 3'd3, 2'd0, 32'd0, 26'd0, 0, 0);
    checkOutput("stallEnter.pc", pc, 32'h84);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("stallHold", 1, 1, 3'd0, 2'd0, 32'd0, 26'd0, 0, 0);
      checkOutput("stallHold.flush", {31'd0, flush}, 32'd1);
      checkOutput("stallHold.pc", pc, 32'h84);
    end
    applyStimulus("stallRel", 1, 0, 3'd0, 2'd0, 32'd0, 26'd0, 0, 0);
    checkOutput("stallRel.flush", {31'd0, flush}, 32'd0);
    checkOutput("stallRel.pc", pc, 32'h84);
    applyStimulus("stallAfter", 1, 0, 3'd0, 2'd0, 32'd0, 26'd0, 0, 0);
    checkOutput("stallAfter.pc", pc, 32'h88);

    // PC wrap at the top of the address space
    applyStimulus("wrapBr", 1, 0, 3'd1, 2'd0, 32'hFFFF_FFFC, 26'd0, 0, 0);
    applyStimulus("wrapFl", 0, 0, 3'd0, 2'd0, 32'd0, 26'd0, 0, 0);
    applyStimulus("wrapSeq", 1, 0, 3'd0, 2'd0, 32'd0, 26'd0, 0, 0);
    checkOutput("wrap.pc", pc, 32'h0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [2:0] rb;
      logic [31:0] rr;
      rb = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      applyStimulus("rand", ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 3) == 0), rb,
                    2'($urandom_range(0, 3)), rr, 26'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted in the middle of a FLUSH, with carry set
    applyStimulus("preRstCarry", 0, 0, 3'd0, 2'd0, 32'd0, 26'd0, 1, 1);
    applyStimulus("preRstBr", 1, 0, 3'd3, 2'd0, 32'd0, 26'd8, 0, 0);
    checkOutput("preRst.flush", {31'd0, flush}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncRst.pc", pc, RST_PC);
    checkOutput("asyncRst.flush", {31'd0, flush}, 32'd0);
    checkOutput("asyncRst.taken", {31'd0, taken}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Carry was cleared, so bcy falls through and the PC restarts from reset
    applyStimulus("postRstBcy", 1, 0, 3'd5, 2'd0, 32'd0, 26'd8, 0, 0);
    checkOutput("postRst.pc", pc, RST_PC + 32'd4);
    checkOutput("postRst.taken", {31'd0, taken}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
